// File: rtl/delta_run_ctrl.sv
// delta_run_ctrl: plays back a small table of trigger-generator burst
// configurations in order, counting generator trig pulses per burst.
module delta_run_ctrl #(
    parameter int unsigned NSTEP = 4,
    parameter int unsigned WD_W  = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       cfg_we,
    input  logic [$clog2(NSTEP)-1:0]   cfg_addr,
    input  logic [31:0]                cfg_gap,
    input  logic [15:0]                cfg_ntrig,
    input  logic [15:0]                cfg_npulse,
    input  logic [15:0]                cfg_dead,
    input  logic [$clog2(NSTEP):0]     cfg_nstep,
    input  logic [WD_W-1:0]            cfg_wd,
    input  logic                       gen_trig,
    output logic                       gen_live,
    output logic                       gen_ena,
    output logic [31:0]                gen_gap,
    output logic [15:0]                gen_ntrig,
    output logic                       busy,
    output logic                       done,
    output logic                       wd_err,
    output logic                       cfg_err,
    output logic [$clog2(NSTEP)-1:0]   step_idx,
    output logic [31:0]                pulse_total
);

    localparam int unsigned AW = $clog2(NSTEP);

    typedef logic [AW-1:0] idx_t;
    typedef logic [AW:0]   nstep_t;

    localparam nstep_t NSTEP_V = nstep_t'(NSTEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DEAD,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] gap;
        logic [15:0] ntrig;
        logic [15:0] npulse;
        logic [15:0] dead;
    } entry_t;

    entry_t          tbl [NSTEP];
    state_t          state;
    state_t          state_nxt;
    idx_t            idx_nxt;
    nstep_t          nstep_q;
    nstep_t          nstep_clamp;
    logic [15:0]     pulse_cnt;
    logic [15:0]     cnt_inc;
    logic [15:0]     dead_cnt;
    logic [15:0]     npulse_cur;
    logic [15:0]     dead_cur;
    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_inc;
    logic            start_go;
    logic            complete;
    logic            timeout;
    logic            wd_fire;
    logic            dead_end;
    logic            last_step;

    // Table storage: writable only while idle, never cleared by reset.
    always_ff @(posedge clk) begin
        if (cfg_we && state == S_IDLE) begin
            tbl[cfg_addr] <= {cfg_gap, cfg_ntrig, cfg_npulse, cfg_dead};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, step index advance and burst completion decisions.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = step_idx;
        npulse_cur  = tbl[step_idx].npulse;
        dead_cur    = tbl[step_idx].dead;
        cnt_inc     = pulse_cnt + 16'(gen_trig);
        wd_inc      = wd_cnt + WD_W'(1);
        start_go    = 1'b0;
        wd_fire     = 1'b0;
        complete    = (npulse_cur != 16'hFFFF) &&
                      ((npulse_cur == 16'd0) || (cnt_inc == npulse_cur));
        timeout     = (cfg_wd != '0) && !gen_trig && (wd_inc >= cfg_wd);
        dead_end    = (17'(dead_cnt) + 17'd1) >= 17'(dead_cur);
        last_step   = (nstep_t'(step_idx) + nstep_t'(1)) == nstep_q;
        nstep_clamp = cfg_nstep;
        if (cfg_nstep == '0) begin
            nstep_clamp = nstep_t'(1);
        end else if (cfg_nstep > NSTEP_V) begin
            nstep_clamp = NSTEP_V;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    start_go  = 1'b1;
                    state_nxt = S_ARM;
                    idx_nxt   = '0;
                end
            end
            S_ARM: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (complete) begin
                    state_nxt = S_DEAD;
                end else if (timeout) begin
                    wd_fire   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DEAD: begin
                if (dead_end) begin
                    if (last_step) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ARM;
                        idx_nxt   = step_idx + idx_t'(1);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides every transition and suppresses start.
        if (abort) begin
            state_nxt = S_IDLE;
            idx_nxt   = step_idx;
            start_go  = 1'b0;
            wd_fire   = 1'b0;
        end
    end

    // Datapath counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nstep_q     <= '0;
            step_idx    <= '0;
            pulse_cnt   <= '0;
            wd_cnt      <= '0;
            dead_cnt    <= '0;
            pulse_total <= '0;
            gen_gap     <= '0;
            gen_ntrig   <= '0;
            gen_live    <= 1'b0;
            gen_ena     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wd_err      <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            step_idx <= idx_nxt;
            gen_live <= (state_nxt == S_RUN);
            gen_ena  <= (state_nxt == S_RUN);
            busy     <= (state_nxt == S_ARM) || (state_nxt == S_RUN) ||
                        (state_nxt == S_DEAD);
            done     <= (state_nxt == S_DONE);
            cfg_err  <= cfg_we && (state != S_IDLE);

            if (state_nxt == S_ARM) begin
                gen_gap   <= tbl[idx_nxt].gap;
                gen_ntrig <= tbl[idx_nxt].ntrig;
            end

            if (state == S_RUN) begin
                pulse_cnt <= cnt_inc;
                wd_cnt    <= gen_trig ? '0 : wd_inc;
            end else begin
                pulse_cnt <= '0;
                wd_cnt    <= '0;
            end

            dead_cnt <= (state == S_DEAD) ? dead_cnt + 16'd1 : 16'd0;

            if (start_go) begin
                nstep_q     <= nstep_clamp;
                pulse_total <= '0;
                wd_err      <= 1'b0;
            end else if (state == S_RUN && gen_trig) begin
                pulse_total <= pulse_total + 32'd1;
            end

            if (wd_fire) begin
                wd_err <= 1'b1;
            end
        end
    end

endmodule
